// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit in front of a synchronous
//               RAM with a one-cycle read latency.
//               - Word stores issue a single RAM write.
//               - Loads issue a RAM read and capture the data one cycle later.
//               Optional feature macro LSU_BYTE_EN:
//               - Adds byte loads, returning the selected lane zero-extended.
//               - Adds byte stores as read-modify-write (read, merge, write).
//               Without the macro every access is a word access.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_byte,
  input  logic              i_req_bsel,
  input  logic [AWIDTH-1:0] i_req_addr,
  input  logic [DWIDTH-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DWIDTH-1:0] o_rsp_rdata,
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [AWIDTH-1:0] o_ram_raddr,
  output logic [AWIDTH-1:0] o_ram_waddr,
  output logic [DWIDTH-1:0] o_ram_wdata,
  input  logic [DWIDTH-1:0] i_ram_rdata
);

  // Two state bits cover all four states; MERGE exists only with byte support.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
`ifdef LSU_BYTE_EN
    ,
    ST_MERGE = 2'd3
`endif
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_ram_wdata;   // store data, later replaced by the merged word
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_ram_rd;
  logic              r_ram_wr;

  logic              w_req_byte;    // incoming request is a byte access
  logic              w_cur_byte;    // latched request is a byte access
  logic [DWIDTH-1:0] w_load_data;   // value returned for the latched load

`ifdef LSU_BYTE_EN
  localparam int c_BYTE_W = 8;

  logic                r_byte;
  logic                r_bsel;
  logic [c_BYTE_W-1:0] w_rd_lane;
  logic [DWIDTH-1:0]   w_merged;

  assign w_req_byte = i_req_byte;
  assign w_cur_byte = r_byte;

  // Selected lane of the returned word, used by byte loads.
  assign w_rd_lane   = r_bsel ? i_ram_rdata[15:8] : i_ram_rdata[7:0];
  assign w_load_data = r_byte ? {{(DWIDTH-c_BYTE_W){1'b0}}, w_rd_lane} : i_ram_rdata;

  // Read-modify-write merge: the store byte replaces one lane, the rest of the word is kept.
  always_comb begin
    w_merged = i_ram_rdata;
    if (r_bsel) begin
      w_merged[15:8] = r_ram_wdata[7:0];
    end else begin
      w_merged[7:0] = r_ram_wdata[7:0];
    end
  end
`else
  // Byte controls have no meaning in a word-only build.
  logic w_unused_byte_ctl;

  assign w_unused_byte_ctl = i_req_byte ^ i_req_bsel;
  assign w_req_byte        = 1'b0;
  assign w_cur_byte        = 1'b0;
  assign w_load_data       = i_ram_rdata;
`endif

  // Control FSM; every output is a register updated on the transition into the cycle it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_ram_wdata <= '0;
      r_rsp_rdata <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
`ifdef LSU_BYTE_EN
      r_byte      <= 1'b0;
      r_bsel      <= 1'b0;
`endif
    end else begin
      // Strobes and the response are single-cycle pulses unless re-armed below.
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_rsp_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_we        <= i_req_we;
            r_addr      <= i_req_addr;
            r_ram_wdata <= i_req_wdata;
`ifdef LSU_BYTE_EN
            r_byte      <= i_req_byte;
            r_bsel      <= i_req_bsel;
`endif
            r_req_ready <= 1'b0;
            r_state     <= ST_ISSUE;
            // Word stores write immediately; loads and byte stores read first.
            if (i_req_we && !w_req_byte) begin
              r_ram_wr <= 1'b1;
            end else begin
              r_ram_rd <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (r_we && !w_cur_byte) begin
            r_rsp_valid <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
`ifdef LSU_BYTE_EN
          if (r_we) begin
            r_ram_wdata <= w_merged;
            r_ram_wr    <= 1'b1;
            r_state     <= ST_MERGE;
          end else
`endif
          begin
            r_rsp_rdata <= w_load_data;
            r_rsp_valid <= 1'b1;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

`ifdef LSU_BYTE_EN
        ST_MERGE: begin
          r_rsp_valid <= 1'b1;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
`endif

        default: begin
          r_req_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_ram_rd    = r_ram_rd;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_raddr = r_addr;
  assign o_ram_waddr = r_addr;
  assign o_ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu with a RAM model and an in-order
//               response scoreboard (expected latency and load data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic          i_req_byte;
  logic          i_req_bsel;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_ram_rd;
  logic          o_ram_wr;
  logic [AW-1:0] o_ram_raddr;
  logic [AW-1:0] o_ram_waddr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  always #5 clk = ~clk;

  lsu #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_byte  (i_req_byte),
    .i_req_bsel  (i_req_bsel),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_ram_rd    (o_ram_rd),
    .o_ram_wr    (o_ram_wr),
    .o_ram_raddr (o_ram_raddr),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (i_ram_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // RAM model: one-cycle read latency, with a preload port for the bench.
  logic [DW-1:0] ram [0:255];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (o_ram_wr) ram[o_ram_waddr] <= o_ram_wdata;
    if (o_ram_rd) i_ram_rdata <= ram[o_ram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: requests pushed on acceptance, memory effects applied on response.
  typedef struct {
    logic          we;
    logic          byt;
    logic          bsel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [0:255];
  logic [DW-1:0] last_rd;
  int            wr_seen = 0;
  exp_t          e;
  logic [DW-1:0] ev;
  logic          byt;
  int            lat;

  always @(negedge clk) begin
    if (pre_en) mdl[pre_addr] = pre_data;
    if (o_ram_wr) wr_seen++;
    chk("rd_wr_excl", 32'(o_ram_rd & o_ram_wr), 32'd0);
    if (!rst) begin
      sb.delete();
      last_rd = '0;
    end else begin
      if (o_rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.due);
          if (e.we) begin
            chk("rsp_hold", o_rsp_rdata, last_rd);
            ev = mdl[e.addr];
            if (!e.byt) ev = e.wdata;
            else if (e.bsel) ev[15:8] = e.wdata[7:0];
            else ev[7:0] = e.wdata[7:0];
            mdl[e.addr] = ev;
          end else begin
            ev = mdl[e.addr];
            if (e.byt) ev = e.bsel ? {8'h00, ev[15:8]} : {8'h00, ev[7:0]};
            chk("rsp_rdata", o_rsp_rdata, ev);
            last_rd = ev;
          end
        end
      end
      if (i_req_valid && o_req_ready) begin
        byt = 1'b0;
`ifdef LSU_BYTE_EN
        byt = i_req_byte;
`endif
        lat = !i_req_we ? 3 : (byt ? 4 : 2);
        sb.push_back('{i_req_we, byt, i_req_bsel, i_req_addr, i_req_wdata, cyc + lat});
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Present a request until it is accepted; returns in the cycle after the handshake.
  task automatic issue(input logic we, input logic b, input logic bs,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, output int hs);
    bit ok = 1'b0;
    i_req_valid = 1'b1; i_req_we = we; i_req_byte = b; i_req_bsel = bs;
    i_req_addr = a; i_req_wdata = d;
    hs = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (o_req_ready) begin ok = 1'b1; hs = cyc; end
    end
    if (!ok) chk("hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 40) begin @(negedge clk); k++; end
    chk("drain", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, o_req_ready, 32'd0);
    chk({tag, "_rsp"},   o_rsp_valid, 32'd0);
    chk({tag, "_rdata"}, o_rsp_rdata, 32'd0);
    chk({tag, "_rd"},    o_ram_rd,    32'd0);
    chk({tag, "_wr"},    o_ram_wr,    32'd0);
    chk({tag, "_raddr"}, o_ram_raddr, 32'd0);
    chk({tag, "_waddr"}, o_ram_waddr, 32'd0);
    chk({tag, "_wdata"}, o_ram_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int h0, h1, h2, wr_base;

  initial begin
    rst = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_byte = 1'b0;
    i_req_bsel = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset held for several cycles while the RAM is preloaded.
    @(posedge clk); #1;
    preload(8'h00, 16'h1111);
    preload(8'h01, 16'h2222);
    preload(8'hFF, 16'hC3A5);
    preload(8'h20, 16'h1234);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", o_req_ready, 32'd1);
    @(posedge clk); #1;

    // Word store then load of the same address.
    issue(1'b1, 1'b0, 1'b0, 8'h10, 16'hBEEF, h0);
    @(negedge clk);
    chk("st_wr", o_ram_wr, 32'd1);
    chk("st_rd", o_ram_rd, 32'd0);
    chk("st_waddr", o_ram_waddr, 32'h10);
    chk("st_wdata", o_ram_wdata, 32'hBEEF);
    chk("st_ready_issue", o_req_ready, 32'd0);
    @(negedge clk);
    chk("st_wr_once", o_ram_wr, 32'd0);
    drain();
    issue(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, h0);
    @(negedge clk);
    chk("ld_rd", o_ram_rd, 32'd1);
    chk("ld_raddr", o_ram_raddr, 32'h10);
    chk("ld_wr", o_ram_wr, 32'd0);
    @(negedge clk);
    chk("ld_rd_once", o_ram_rd, 32'd0);
    chk("ld_ready_wait", o_req_ready, 32'd0);
    drain();
    chk("ld_rdata", o_rsp_rdata, 32'hBEEF);

    // Streaming loads with valid held high, including the top address.
    issue(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, h0);
    issue(1'b0, 1'b0, 1'b0, 8'h01, 16'h0000, h1);
    issue(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0000, h2);
    @(negedge clk);
    chk("ld_ff_raddr", o_ram_raddr, 32'hFF);
    chk("acc_gap1", h1 - h0, 32'd3);
    chk("acc_gap2", h2 - h1, 32'd3);
    drain();
    chk("ld_ff_rdata", o_rsp_rdata, 32'hC3A5);

    // Back-to-back store then load.
    issue(1'b1, 1'b0, 1'b0, 8'h40, 16'h5A5A, h0);
    issue(1'b0, 1'b0, 1'b0, 8'h40, 16'h0000, h1);
    chk("b2b_gap", h1 - h0, 32'd2);
    drain();
    chk("b2b_rdata", o_rsp_rdata, 32'h5A5A);

    // Byte store to the upper lane of 0x1234.
    issue(1'b1, 1'b1, 1'b1, 8'h20, 16'h00AB, h0);
`ifdef LSU_BYTE_EN
    @(negedge clk);
    chk("bst_rd", o_ram_rd, 32'd1);
    chk("bst_wr0", o_ram_wr, 32'd0);
    @(negedge clk);
    chk("bst_wait_rd", o_ram_rd, 32'd0);
    chk("bst_wait_wr", o_ram_wr, 32'd0);
    @(negedge clk);
    chk("bst_wr", o_ram_wr, 32'd1);
    chk("bst_waddr", o_ram_waddr, 32'h20);
    chk("bst_wdata", o_ram_wdata, 32'hAB34);
    drain();
    chk("bst_ram", ram[8'h20], 32'hAB34);
    issue(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, h0);
    drain();
    chk("bld_rdata", o_rsp_rdata, 32'h0034);
`else
    @(negedge clk);
    chk("bst_wr", o_ram_wr, 32'd1);
    chk("bst_rd", o_ram_rd, 32'd0);
    chk("bst_wdata", o_ram_wdata, 32'h00AB);
    @(negedge clk);
    chk("bst_wr_once", o_ram_wr, 32'd0);
    drain();
    chk("bst_ram", ram[8'h20], 32'h00AB);
`endif

    // Reset asserted in the WAIT cycle abandons the request.
    preload(8'h20, 16'h1234);
`ifdef LSU_BYTE_EN
    issue(1'b1, 1'b1, 1'b1, 8'h20, 16'h00CD, h0);
`else
    issue(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, h0);
`endif
    @(posedge clk); #1;
    wr_base = wr_seen;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready", o_req_ready, 32'd1);
    repeat (5) @(negedge clk);
    chk("midrst_no_wr", wr_seen, wr_base);
    chk("midrst_ram", ram[8'h20], 32'h1234);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, h0);
    drain();
    chk("midrst_rdata", o_rsp_rdata, 32'h1234);

    repeat (4) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter AWIDTH, default 8: RAM word-address width.
REQ-002 Parameter DWIDTH, default 16: RAM data width, fixed even (byte lanes [7:0], [15:8]).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 i_req_valid  in  1  request present.
REQ-006 o_req_ready  out  1  LSU can accept; handshake = i_req_valid & o_req_ready at rising edge.
REQ-007 i_req_we  in  1  1 = store, 0 = load.
REQ-008 i_req_byte  in  1  byte-size access (used only when LSU_BYTE_EN is defined).
REQ-009 i_req_bsel  in  1  byte lane: 0 = [7:0], 1 = [15:8] (used only when LSU_BYTE_EN is defined).
REQ-010 i_req_addr  in  AWIDTH  word address.
REQ-011 i_req_wdata  in  DWIDTH  store data; byte stores take bits [7:0].
REQ-012 o_rsp_valid  out  1  one-cycle completion pulse for every accepted request (load and store).
REQ-013 o_rsp_rdata  out  DWIDTH  load result; updates only on load completion, otherwise holds.
REQ-014 o_ram_rd, o_ram_wr  out  1 each  RAM read and write strobes.
REQ-015 o_ram_raddr, o_ram_waddr  out  AWIDTH  RAM addresses, both driven from the latched request address.
REQ-016 o_ram_wdata  out  DWIDTH  RAM write data.
REQ-017 i_ram_rdata  in  DWIDTH  RAM read data; valid in the cycle after the one in which o_ram_rd is high.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, MERGE; o_req_ready = 1 only in IDLE while rst is high.
REQ-019 IDLE: on handshake, latch we/byte/bsel/addr/wdata and go to ISSUE; otherwise stay.
REQ-020 ISSUE, word store: o_ram_wr = 1 for exactly this cycle with latched addr/wdata; go to IDLE; o_rsp_valid = 1 in the next cycle.
REQ-021 ISSUE, load or byte store: o_ram_rd = 1 for exactly this cycle; go to WAIT.
REQ-022 WAIT, load: capture i_ram_rdata (word, or zero-extended selected byte) into o_rsp_rdata; go to IDLE; o_rsp_valid = 1 in the next cycle.
REQ-023 WAIT, byte store: merge wdata[7:0] into the selected lane of i_ram_rdata, keeping the other lane; go to MERGE.
REQ-024 MERGE: o_ram_wr = 1 for exactly this cycle with the merged word; go to IDLE; o_rsp_valid = 1 in the next cycle.
REQ-025 Latency from handshake edge N: word store rsp at cycle N+2; load rsp at N+3; byte store rsp at N+4.
REQ-026 Handshake is allowed in the same cycle as o_rsp_valid, giving back-to-back operation; responses are returned strictly in order.
REQ-027 o_ram_rd and o_ram_wr are never both high; outside the cycles above both are 0.
REQ-028 Request inputs are ignored outside IDLE; all addresses 0 to 2^AWIDTH-1 are legal, with no wrap logic.

Reset
REQ-029 While rst = 0, on each edge: state = IDLE, o_req_ready = 0, o_rsp_valid = 0, o_rsp_rdata = 0, all o_ram_* = 0.
REQ-030 Reset mid-operation abandons the request: no later o_ram_wr and no o_rsp_valid for it; o_req_ready = 1 in the first cycle after rst returns to 1.

Configuration
REQ-031 Macro LSU_BYTE_EN defined: byte loads and read-modify-write byte stores per REQ-021 to REQ-024.
REQ-032 Macro LSU_BYTE_EN undefined: i_req_byte and i_req_bsel are ignored; every access is a word access; the MERGE state is not implemented.

Verification
REQ-033 Reset: rst = 0 for 3 cycles -> all outputs 0; release rst -> o_req_ready = 1 in the next cycle.
REQ-034 Word store addr 0x10, data 0xBEEF -> o_ram_wr at N+1 with waddr 0x10, wdata 0xBEEF; rsp at N+2. Then load 0x10 -> o_ram_rd at N+1; rsp at N+3 with rdata 0xBEEF.
REQ-035 i_req_valid held high for loads 0x00, 0x01, 0xFF -> one accept per 3 cycles, ready = 0 in ISSUE/WAIT, responses in order, address 0xFF reached correctly.
REQ-036 With LSU_BYTE_EN and RAM[0x20] = 0x1234: byte store bsel = 1, data 0x00AB -> o_ram_rd then o_ram_wr with 0xAB34, rsp at N+4. Then byte load 0x20 bsel = 0 -> rdata 0x0034.
REQ-037 Without LSU_BYTE_EN, same byte store -> single o_ram_wr with 0x00AB, rsp at N+2.
REQ-038 rst = 0 asserted during WAIT of a byte store -> no o_ram_wr, no o_rsp_valid, RAM[0x20] unchanged, ready = 1 after release.
